// File: rtl/sha_pkg.sv
// Shared SHA-256 types and message-layout constants for the double-hash
// datapath and its nonce scheduler.
package sha_pkg;

  typedef logic [7:0][31:0] HashState;

  localparam logic [31:0] SHA_PAD_WORD    = 32'h8000_0000;
  localparam logic [31:0] HEADER_LEN_BITS = 32'h0000_0280;
  localparam int          MSG_WORDS       = 32;
  localparam int          HDR_WORDS       = 20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FEED,
    S_DRAIN
  } sched_state_e;

endpackage

// File: rtl/nonce_inflight_fifo.sv
// Small synchronous FIFO holding the nonces of hashes issued but not yet
// returned; head is the nonce of the oldest outstanding hash.
module nonce_inflight_fifo #(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = do_pop ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sha_nonce_scheduler.sv
// Sweeps the nonce of a stored 80-byte header across a range, streams one
// padded 32-word message per nonce into the double hasher, and reports hits.
module sha_nonce_scheduler
  import sha_pkg::*;
#(
  parameter int INFLIGHT  = 2,
  parameter int NONCE_IDX = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tmpl_we,
  input  logic [4:0]  tmpl_addr,
  input  logic [31:0] tmpl_wdata,
  input  logic        job_start,
  input  logic [31:0] nonce_first,
  input  logic [31:0] nonce_last,
  input  logic [31:0] target,
  input  logic        job_abort,
  output logic        dh_start,
  output logic [31:0] dh_M,
  input  logic        dh_input_valid,
  input  HashState    dh_hash,
  input  logic        dh_hash_valid,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic        err
);

  localparam int         CW     = $clog2(INFLIGHT + 1);
  localparam logic [4:0] NIDX   = 5'(NONCE_IDX);
  localparam logic [4:0] PAD_W  = 5'(HDR_WORDS);
  localparam logic [4:0] LAST_W = 5'(MSG_WORDS - 1);

  sched_state_e state_q, state_d;
  logic [4:0]   widx_q, widx_d;
  logic [31:0]  nonce_q, nonce_d;
  logic [31:0]  last_q, last_d;
  logic [31:0]  target_q, target_d;
  logic         aborted_q, aborted_d;
  logic         dh_start_q, dh_start_d;
  logic         done_q, done_d;
  logic         found_q, found_d;
  logic [31:0]  found_nonce_q, found_nonce_d;
  logic         err_q, err_d;
  logic [31:0]  tmpl_q [HDR_WORDS];
  logic [31:0]  msg_word;
  logic         push, pop, hit, tmpl_wr, accept;
  logic [31:0]  fifo_head;
  logic [CW-1:0] fifo_count;
  logic         fifo_empty, fifo_full;
  logic         unused_hash;

  nonce_inflight_fifo #(.DEPTH(INFLIGHT)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (nonce_q),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign unused_hash = ^{dh_hash[6:0], fifo_count};

  assign busy        = (state_q != S_IDLE);
  assign accept      = (state_q == S_IDLE) && job_start;
  assign tmpl_wr     = tmpl_we && !busy && (tmpl_addr < PAD_W);
  assign pop         = dh_hash_valid && !fifo_empty;
  assign hit         = pop && (dh_hash[7] <= target_q) && !aborted_q;
  assign dh_start    = dh_start_q;
  assign dh_M        = msg_word;
  assign done        = done_q;
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign err         = err_q;

  // Outside FEED (including the drain after an abort) the hasher sees zeros.
  always_comb begin
    msg_word = '0;
    if (state_q == S_FEED) begin
      if (widx_q == NIDX)        msg_word = nonce_q;
      else if (widx_q < PAD_W)   msg_word = tmpl_q[widx_q];
      else if (widx_q == PAD_W)  msg_word = SHA_PAD_WORD;
      else if (widx_q == LAST_W) msg_word = HEADER_LEN_BITS;
    end
  end

  always_comb begin
    state_d       = state_q;
    widx_d        = dh_input_valid ? widx_q + 5'd1 : widx_q;
    nonce_d       = nonce_q;
    last_d        = last_q;
    target_d      = target_q;
    aborted_d     = aborted_q;
    dh_start_d    = 1'b0;
    done_d        = 1'b0;
    push          = 1'b0;
    found_d       = hit;
    found_nonce_d = hit ? fifo_head : found_nonce_q;
    err_d         = accept ? 1'b0 : err_q;
    if (dh_hash_valid && fifo_empty) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          nonce_d   = nonce_first;
          last_d    = nonce_last;
          target_d  = target;
          aborted_d = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (job_abort) begin
          aborted_d = 1'b1;
          state_d   = S_DRAIN;
        end else if (!fifo_full) begin
          dh_start_d = 1'b1;
          push       = 1'b1;
          widx_d     = '0;
          state_d    = S_FEED;
        end
      end
      S_FEED: begin
        if (job_abort) begin
          aborted_d = 1'b1;
          state_d   = S_DRAIN;
        end else if (dh_input_valid && (widx_q == LAST_W)) begin
          if (nonce_q == last_q) begin
            state_d = S_DRAIN;
          end else begin
            nonce_d = nonce_q + 32'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          done_d    = 1'b1;
          aborted_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      widx_q        <= '0;
      aborted_q     <= 1'b0;
      dh_start_q    <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      widx_q        <= widx_d;
      aborted_q     <= aborted_d;
      dh_start_q    <= dh_start_d;
      done_q        <= done_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      err_q         <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    nonce_q  <= nonce_d;
    last_q   <= last_d;
    target_q <= target_d;
    if (tmpl_wr) tmpl_q[tmpl_addr] <= tmpl_wdata;
  end

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Directed bench for sha_nonce_scheduler with a behavioural hasher that
// consumes 32 words per start and returns a result after a set latency.
module tb_sha_nonce_scheduler;
  import sha_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tmpl_we = 1'b0;
  logic [4:0]  tmpl_addr = '0;
  logic [31:0] tmpl_wdata = '0;
  logic        job_start = 1'b0;
  logic [31:0] nonce_first = '0;
  logic [31:0] nonce_last = '0;
  logic [31:0] target = '0;
  logic        job_abort = 1'b0;
  logic        dh_start;
  logic [31:0] dh_M;
  logic        dh_input_valid = 1'b0;
  HashState    dh_hash = '0;
  logic        dh_hash_valid = 1'b0;
  logic        busy, done, found, err;
  logic [31:0] found_nonce;

  int tests = 0;
  int failed = 0;

  int cyc = 0, lat = 3, feed_left = 0;
  int starts = 0, results = 0, max_out = 0, done_cnt = 0;
  logic [31:0] res_w7 = '0;
  logic        busy_at_done = 1'b0;
  logic [31:0] cap[$];
  logic [31:0] found_log[$];
  int          due[$];

  sha_nonce_scheduler #(.INFLIGHT(2), .NONCE_IDX(19)) dut (
    .clk            (clk),
    .rst            (rst),
    .tmpl_we        (tmpl_we),
    .tmpl_addr      (tmpl_addr),
    .tmpl_wdata     (tmpl_wdata),
    .job_start      (job_start),
    .nonce_first    (nonce_first),
    .nonce_last     (nonce_last),
    .target         (target),
    .job_abort      (job_abort),
    .dh_start       (dh_start),
    .dh_M           (dh_M),
    .dh_input_valid (dh_input_valid),
    .dh_hash        (dh_hash),
    .dh_hash_valid  (dh_hash_valid),
    .busy           (busy),
    .done           (done),
    .found          (found),
    .found_nonce    (found_nonce),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Hasher model and event recorder, evaluated at every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      dh_hash_valid = 1'b0;
      if (due.size() > 0 && due[0] <= cyc) begin
        void'(due.pop_front());
        dh_hash       = '0;
        dh_hash[7]    = res_w7;
        dh_hash_valid = 1'b1;
        results++;
      end
      if (dh_start) begin
        starts++;
        feed_left = MSG_WORDS;
        if (starts - results > max_out) max_out = starts - results;
      end
      if (feed_left > 0) begin
        cap.push_back(dh_M);
        dh_input_valid = 1'b1;
        feed_left--;
        if (feed_left == 0) due.push_back(cyc + lat);
      end else begin
        dh_input_valid = 1'b0;
      end
      if (found) found_log.push_back(found_nonce);
      if (done) begin
        done_cnt++;
        busy_at_done = busy;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      step(1);
      n++;
    end
    check32(tag, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic wait_starts(input string tag, input int want, input int budget);
    int n;
    n = 0;
    while (starts < want && n < budget) begin
      step(1);
      n++;
    end
    check32(tag, 32'(starts), 32'(want));
  endtask

  task automatic write_tmpl(input logic [4:0] a, input logic [31:0] d);
    tmpl_we    = 1'b1;
    tmpl_addr  = a;
    tmpl_wdata = d;
    step(1);
    tmpl_we = 1'b0;
  endtask

  task automatic new_job(input logic [31:0] f, input logic [31:0] l, input logic [31:0] t,
                         input int latency, input logic [31:0] w7);
    lat    = latency;
    res_w7 = w7;
    cap.delete();
    found_log.delete();
    starts  = 0;
    results = 0;
    max_out = 0;
    nonce_first = f;
    nonce_last  = l;
    target      = t;
    job_start   = 1'b1;
    step(1);
    job_start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_dh_start"}, 32'(dh_start), 32'd0);
    check32({tag, "_dh_M"}, dh_M, 32'd0);
    check32({tag, "_busy"}, 32'(busy), 32'd0);
    check32({tag, "_done"}, 32'(done), 32'd0);
    check32({tag, "_found"}, 32'(found), 32'd0);
    check32({tag, "_found_nonce"}, found_nonce, 32'd0);
    check32({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int fc, d0;

    rst = 1'b0;
    step(3);
    check_reset_outputs("reset");
    rst = 1'b1;
    step(2);
    for (int i = 0; i < 20; i++) write_tmpl(5'(i), 32'h1000_0000 + 32'(i));

    // Basic sweep 5..7, every result is a hit.
    new_job(32'd5, 32'd7, 32'hFFFF_FFFF, 3, 32'h1234_5678);
    check32("t1_busy_rise", 32'(busy), 32'd1);
    check32("t1_start_lag", 32'(dh_start), 32'd0);
    tmpl_we = 1'b1; tmpl_addr = 5'd0; tmpl_wdata = 32'hBAD0_BAD0;
    step(1);
    tmpl_we = 1'b0;
    check32("t1_start_pulse", 32'(dh_start), 32'd1);
    d0 = done_cnt;
    wait_done("t1_done", 1000);
    check32("t1_busy_at_done", 32'(busy_at_done), 32'd0);
    check32("t1_starts", 32'(starts), 32'd3);
    check32("t1_words", 32'(cap.size()), 32'd96);
    check32("t1_w0", cap[0], 32'h1000_0000);
    check32("t1_w18", cap[18], 32'h1000_0012);
    check32("t1_nonce5", cap[19], 32'd5);
    check32("t1_nonce6", cap[51], 32'd6);
    check32("t1_nonce7", cap[83], 32'd7);
    check32("t1_busy_write_ignored", cap[64], 32'h1000_0000);
    check32("t1_pad", cap[20], 32'h8000_0000);
    check32("t1_zero", cap[25], 32'd0);
    check32("t1_len", cap[31], 32'h0000_0280);
    check32("t1_found_cnt", 32'(found_log.size()), 32'd3);
    check32("t1_found0", found_log[0], 32'd5);
    check32("t1_found1", found_log[1], 32'd6);
    check32("t1_found2", found_log[2], 32'd7);
    step(3);
    check32("t1_done_once", 32'(done_cnt - d0), 32'd1);
    check32("t1_err", 32'(err), 32'd0);

    // Target 0 with nonzero hash word 7: no hits.
    new_job(32'd10, 32'd11, 32'd0, 3, 32'd1);
    wait_done("t2_done", 1000);
    check32("t2_found_cnt", 32'(found_log.size()), 32'd0);
    check32("t2_starts", 32'(starts), 32'd2);
    check32("t2_nonce10", cap[19], 32'd10);
    check32("t2_nonce11", cap[51], 32'd11);
    check32("t2_err", 32'(err), 32'd0);

    // Single nonce, hash word 7 exactly equal to the target is a hit.
    new_job(32'd20, 32'd20, 32'h55, 3, 32'h55);
    wait_done("t2b_done", 1000);
    check32("t2b_starts", 32'(starts), 32'd1);
    check32("t2b_found_cnt", 32'(found_log.size()), 32'd1);
    check32("t2b_found", found_log[0], 32'd20);

    // Wrap-around sweep, 1-cycle latency so each pop meets the next push;
    // template word 1 written in the same cycle as job_start.
    tmpl_we = 1'b1; tmpl_addr = 5'd1; tmpl_wdata = 32'h1111_1111;
    new_job(32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 1, 32'hABCD_0000);
    tmpl_we = 1'b0;
    wait_done("t3_done", 2000);
    check32("t3_starts", 32'(starts), 32'd4);
    check32("t3_same_cycle_write", cap[1], 32'h1111_1111);
    check32("t3_nonce2", cap[83], 32'd0);
    check32("t3_nonce3", cap[115], 32'd1);
    check32("t3_found_cnt", 32'(found_log.size()), 32'd4);
    check32("t3_found0", found_log[0], 32'hFFFF_FFFE);
    check32("t3_found1", found_log[1], 32'hFFFF_FFFF);
    check32("t3_found2", found_log[2], 32'h0000_0000);
    check32("t3_found3", found_log[3], 32'h0000_0001);
    check32("t3_err", 32'(err), 32'd0);

    // Long latency: never more than two outstanding hashes.
    new_job(32'd0, 32'd4, 32'hFFFF_FFFF, 100, 32'd9);
    wait_done("t4_done", 3000);
    check32("t4_starts", 32'(starts), 32'd5);
    check32("t4_max_inflight", 32'(max_out), 32'd2);
    check32("t4_found_cnt", 32'(found_log.size()), 32'd5);
    check32("t4_found_last", found_log[4], 32'd4);

    // Abort while feeding nonce 3; results returned afterwards are silent.
    new_job(32'd0, 32'd9, 32'hFFFF_FFFF, 50, 32'd0);
    wait_starts("t5_reach_nonce3", 4, 1000);
    step(5);
    fc = found_log.size();
    job_abort = 1'b1;
    step(1);
    job_abort = 1'b0;
    d0 = done_cnt;
    wait_done("t5_done", 500);
    step(150);
    check32("t5_done_once", 32'(done_cnt - d0), 32'd1);
    check32("t5_no_found_after_abort", 32'(found_log.size()), 32'(fc));
    check32("t5_no_more_starts", 32'(starts), 32'd4);
    check32("t5_word_before_abort", cap[99], 32'h1000_0003);
    check32("t5_nonce_slot_zeroed", cap[115], 32'd0);
    check32("t5_len_zeroed", cap[cap.size() - 1], 32'd0);
    check32("t5_busy", 32'(busy), 32'd0);
    check32("t5_err", 32'(err), 32'd0);

    // Result with nothing in flight sets the sticky error.
    fc = found_log.size();
    due.push_back(cyc + 1);
    step(3);
    check32("t6_err_set", 32'(err), 32'd1);
    check32("t6_no_found", 32'(found_log.size()), 32'(fc));
    step(5);
    check32("t6_err_sticky", 32'(err), 32'd1);

    // Asynchronous reset in the middle of a feed.
    new_job(32'd40, 32'd40, 32'hFFFF_FFFF, 5, 32'd0);
    check32("t7_err_cleared_by_start", 32'(err), 32'd0);
    wait_starts("t7_started", 1, 100);
    step(3);
    check32("t7_feeding_busy", 32'(busy), 32'd1);
    check32("t7_feeding_word", dh_M, 32'h1000_0003);
    rst = 1'b0;
    #1;
    check_reset_outputs("t7_async");
    feed_left      = 0;
    due.delete();
    dh_input_valid = 1'b0;
    dh_hash_valid  = 1'b0;
    d0 = done_cnt;
    step(2);
    rst = 1'b1;
    step(3);
    check32("t7_idle_after", 32'(busy), 32'd0);
    check32("t7_no_done", 32'(done_cnt - d0), 32'd0);

    // A fresh job after reset starts from an empty in-flight FIFO.
    new_job(32'd7, 32'd7, 32'hFFFF_FFFF, 3, 32'd0);
    wait_done("t8_done", 500);
    check32("t8_found_cnt", 32'(found_log.size()), 32'd1);
    check32("t8_found", found_log[0], 32'd7);
    check32("t8_err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sha_nonce_scheduler.md
# sha_nonce_scheduler

Work scheduler for the pipelined SHA-256 double-hash datapath (`sha_simple_doublehash`). Holds one 80-byte header template, sweeps the nonce word across a programmed range and issues one double hash per nonce. Streams the padded 32-word message into the hasher on demand, and tracks in-flight nonces so results match in order. Compares each result against a target and reports hits to the host.

## Interface
Parameters:
- `INFLIGHT`, 2: maximum hashes issued but not yet returned (1..8).
- `NONCE_IDX`, 19: header word index replaced by the nonce.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `tmpl_we`  in  1  template write strobe; honoured only while `busy`=0.
- `tmpl_addr`  in  5  template word index, 0..19. Writes to 20..31 are ignored.
- `tmpl_wdata`  in  32  template word.
- `job_start`  in  1  one-cycle request; accepted only while `busy`=0.
- `nonce_first`  in  32  first nonce; sampled on an accepted `job_start`.
- `nonce_last`  in  32  last nonce, inclusive; sampled on an accepted `job_start`.
- `target`  in  32  hit threshold; sampled on an accepted `job_start`.
- `job_abort`  in  1  stop issuing and drain silently.
- `dh_start`  out  1  one-cycle start pulse to the hasher's start/reset input.
- `dh_M`  out  32  message word to the hasher.
- `dh_input_valid`  in  1  hasher is consuming a word this cycle.
- `dh_hash`  in  HashState  hasher result.
- `dh_hash_valid`  in  1  result valid, one cycle.
- `busy`  out  1  job in progress, including drain.
- `done`  out  1  one-cycle pulse when a job ends normally or after an abort.
- `found`  out  1  one-cycle pulse on a hit.
- `found_nonce`  out  32  nonce of the latest hit; held until the next hit.
- `err`  out  1  sticky; set when a result arrives with no nonce in flight. Cleared by reset or an accepted `job_start`.

## Operation
- Message stream, indexed by `widx` 0..31:
  - words 0..19 come from the template;
  - word `NONCE_IDX` is the current nonce;
  - word 20 = 0x80000000;
  - words 21..30 = 0;
  - word 31 = 0x00000280.
- `dh_M` is a combinational function of the registered `widx` and the current nonce.
- `widx` increments in every cycle that `dh_input_valid`=1.
- States:
  - IDLE: `job_start` latches the job parameters, sets `nonce` = `nonce_first`, goes to ISSUE.
  - ISSUE: if the FIFO holds fewer than `INFLIGHT` entries, pulse `dh_start`, push `nonce` into the in-flight FIFO, clear `widx`, go to FEED. Otherwise stay.
  - FEED: feed words. When `widx`=31 is consumed:
    - if `nonce`==`nonce_last`, go to DRAIN;
    - else set `nonce` = `nonce`+1 (mod 2^32) and go to ISSUE.
  - DRAIN: wait until the FIFO is empty, pulse `done`, go to IDLE.
- Result handling, in any state: `dh_hash_valid` pops the FIFO head.
  - If hash word 7 ≤ `target` (unsigned) and the job is not aborted: `found`=1 and `found_nonce` = popped nonce.
  - If the FIFO is empty: no pop; set `err`.
- `job_abort` in ISSUE or FEED:
  - go to DRAIN at once; `dh_M` drives 0 for any remaining requested words;
  - set an aborted flag that suppresses `found` until IDLE.
  - `job_abort` in IDLE or DRAIN is ignored.
- Wrap-around: `nonce_last` < `nonce_first` sweeps through 0xFFFFFFFF to 0. `nonce_first`==`nonce_last` issues exactly one hash.

## Timing
- Reset values: `dh_start`=0, `dh_M`=0, `busy`=0, `done`=0, `found`=0, `found_nonce`=0, `err`=0; state IDLE, FIFO empty.
- `busy` rises the cycle after an accepted `job_start` and falls together with the `done` pulse.
- `dh_start` rises 1 cycle after entry to ISSUE when the FIFO has room.
- `found` is registered: it rises 1 cycle after the `dh_hash_valid` that produced the hit.
- Simultaneous push (ISSUE) and pop (result) in one cycle is legal; the occupancy count stays unchanged.
- `job_start` together with `tmpl_we` in IDLE: the write lands and the job uses the new word.

## Structure
- `sha_pkg` (existing) holds `HashState` plus new constants `SHA_PAD_WORD` = 0x80000000, `HEADER_LEN_BITS` = 32'h280, `MSG_WORDS` = 32.
- Sub-module `nonce_inflight_fifo`: synchronous FIFO, 32-bit wide, depth `INFLIGHT`, with push, pop, count, empty and full.

## Test plan
- Template of words 0..19, range 5..7, target 0xFFFFFFFF → three `dh_start` pulses, 32 words each. Word 19 reads 5, 6 and 7 in turn. Three `found` pulses with `found_nonce` 5, 6, 7, then `done`.
- Target 0, results with hash word 7 nonzero → no `found`; `done` after the last result; `err`=0.
- Range 0xFFFFFFFE..0x00000001 → four hashes with nonces FFFFFFFE, FFFFFFFF, 0, 1 in order.
- `INFLIGHT`=2 with the hasher model delaying results by 100 cycles → never more than 2 unreturned starts. A simultaneous push and pop keeps the count.
- `job_abort` during FEED of nonce 3, with hits returned after the abort → no `found`; a single `done` once the FIFO is empty; `busy` falls.
- `dh_hash_valid` in IDLE → `err`=1 and stays set. Assert `rst` low mid-FEED → all outputs return to their reset values immediately.
